result_uart_tx: RTL and testbench
=================================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 16; width of one result word.
REQ-002 Parameter FIFO_DEPTH, default 8; number of result words buffered; power of two.
REQ-003 Parameter CLKS_PER_BIT, default 868; clock cycles per UART bit (100 MHz / 115200).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_in  input  DATA_WIDTH  result word from the processor's data output.
REQ-007 data_valid  input  1  one-cycle strobe; data_in is valid this cycle.
REQ-008 tx  output  1  UART serial line, 8N1, idle high, registered.
REQ-009 busy  output  1  high while the FIFO is non-empty or a word is being sent.
REQ-010 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words currently stored.
REQ-011 overflow  output  1  sticky; a word was dropped because the FIFO was full.

Function
REQ-012 When data_valid=1 and the FIFO is not full, data_in SHALL be written at that clock edge.
REQ-013 When data_valid=1 and the FIFO is full with no pop in the same cycle, the word SHALL be dropped and overflow SHALL be set until reset.
REQ-014 If a push and a pop occur in the same cycle with the FIFO full, both SHALL take effect, and count and overflow SHALL be unchanged.
REQ-015 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 The sequencer FSM SHALL have four states, with transitions as listed.
- IDLE: if the FIFO is non-empty, pop the head word into a shift register, set char_idx=0, go to START; otherwise stay.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles; then if char_idx<5, increment char_idx and go to START; else go to IDLE.
REQ-017 Each word SHALL be sent as 6 characters with no gap between them.
- Characters 0..3: hex nibbles, MSB nibble first, uppercase ASCII ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
- Character 4: 0x0D. Character 5: 0x0A.
REQ-018 One word frame SHALL last exactly 60*CLKS_PER_BIT cycles, followed by at least 1 cycle in IDLE before the next pop.
REQ-019 Latency with the FIFO empty and the FSM in IDLE:
- data_valid sampled at edge N, word stored.
- Pop occurs at edge N+1.
- tx first reads 0 after edge N+2 and stays 0 for CLKS_PER_BIT cycles.
REQ-020 The bit timer SHALL count 0..CLKS_PER_BIT-1 and SHALL reset on every state and bit change.
REQ-021 tx SHALL be 1 in IDLE and SHALL show no glitches; it is driven from a flop only.
REQ-022 busy SHALL equal (state!=IDLE) OR (fifo_count!=0), evaluated combinationally from registered state.
REQ-023 fifo_count SHALL never exceed FIFO_DEPTH and SHALL never underflow.

Reset
REQ-024 On reset=1 at an edge, the following SHALL hold after that edge:
- state=IDLE, tx=1, FIFO pointers and count=0, overflow=0, bit timer=0, char_idx=0.
REQ-025 Reset mid-frame SHALL abort the character immediately; tx=1 after that edge; no partial character is resumed.
REQ-026 data_valid asserted during reset SHALL be ignored.

Structure
REQ-027 DATA_WIDTH, the ASCII constants (0x30, 0x41, 0x0D, 0x0A) and the sequencer state encoding SHALL live in the shared processor package.
REQ-028 The FIFO, the nibble-to-ASCII mapping and the FSM SHALL reside in result_uart_tx.
REQ-029 The bit-level serializer SHALL be one sub-module, uart_byte_tx.
- Inputs: clk, reset, byte, start.
- Outputs: tx, done.

Verification (bench uses CLKS_PER_BIT=4)
REQ-030 Single word: push 0x1A2F -> tx carries 0x31,0x41,0x32,0x46,0x0D,0x0A; start bit begins 2 cycles after the push; frame lasts 240 cycles; busy then drops to 0.
REQ-031 Extremes: push 0x0000, then 0xFFFF -> "0000\r\n" then "FFFF\r\n"; at least 1 idle cycle between the frames; fifo_count goes 1,2,1,0.
REQ-032 Overflow: push 10 words 0x0001..0x000A on consecutive cycles from empty -> the first pops at once, 8 are stored, 0x000A is dropped, overflow=1; all 9 remaining words are received in order.
REQ-033 Full push+pop: FIFO full, data_valid asserted in the exact cycle of an IDLE pop -> word accepted, fifo_count stays 8, overflow stays 0.
REQ-034 Reset mid-frame: reset during the DATA bit 3 of character 2 -> tx=1 after the next edge, fifo_count=0, busy=0; a following push of 0x00FF sends "00FF\r\n" correctly.
REQ-035 A UART monitor SHALL check every start bit and stop bit and the bit width (exactly 4 cycles) across all scenarios.

Source files
------------

// File: rtl/result_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_uart_tx_pkg
// Purpose  : Shared word width, ASCII constants, sequencer state encoding and
//            the nibble-to-ASCII helper for the result UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package result_uart_tx_pkg;

    localparam int unsigned c_DATA_WIDTH     = 16;
    localparam int unsigned c_HEX_CHARS      = 4;
    localparam int unsigned c_CHARS_PER_WORD = 6;

    localparam logic [7:0] c_ASCII_ZERO = 8'h30;
    localparam logic [7:0] c_ASCII_A    = 8'h41;
    localparam logic [7:0] c_ASCII_CR   = 8'h0D;
    localparam logic [7:0] c_ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } seq_state_t;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return c_ASCII_ZERO + {4'd0, nib};
        end
        return c_ASCII_A + {4'd0, nib - 4'd10};
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_tx
// Purpose  : 8N1 bit serializer; a start pulse in the last stop-bit cycle
//            chains the next character with no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import result_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       start,
    output logic       tx,
    output logic       done
);

    localparam int unsigned     c_TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(CLKS_PER_BIT - 1);

    seq_state_t      r_state_q, w_state_d;
    logic [c_TW-1:0] r_timer_q, w_timer_d;
    logic [2:0]      r_bit_q,   w_bit_d;
    logic [7:0]      r_shift_q, w_shift_d;
    logic            r_tx_q,    w_tx_d;
    logic            w_bit_end;

    assign w_bit_end = (r_timer_q == c_TMAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_timer_q <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_tx_q    <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_timer_q <= w_timer_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_tx_q    <= w_tx_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_timer_d = w_bit_end ? '0 : r_timer_q + 1'b1;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_tx_d    = r_tx_q;
        case (r_state_q)
            ST_IDLE: begin
                w_timer_d = '0;
                w_tx_d    = 1'b1;
                if (start) begin
                    w_state_d = ST_START;
                    w_shift_d = byte_in;
                    w_tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_d = ST_DATA;
                    w_bit_d   = '0;
                    w_tx_d    = r_shift_q[0];
                    w_shift_d = {1'b0, r_shift_q[7:1]};
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_q == 3'd7) begin
                        w_state_d = ST_STOP;
                        w_tx_d    = 1'b1;
                    end else begin
                        w_bit_d   = r_bit_q + 3'd1;
                        w_tx_d    = r_shift_q[0];
                        w_shift_d = {1'b0, r_shift_q[7:1]};
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (start) begin
                        w_state_d = ST_START;
                        w_shift_d = byte_in;
                        w_tx_d    = 1'b0;
                    end else begin
                        w_state_d = ST_IDLE;
                        w_tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_tx_d    = 1'b1;
            end
        endcase
    end

    assign tx   = r_tx_q;
    assign done = (r_state_q == ST_STOP) && w_bit_end;

endmodule
`default_nettype wire

// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : result_uart_tx
// Purpose  : Buffers result words in a FIFO and prints each one over UART as
//            four uppercase hex digits followed by CR LF.
// Revision : 1.0 - initial release
// ============================================================================
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = c_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        data_valid,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int unsigned     c_AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned     c_CW   = c_AW + 1;
    localparam int unsigned     c_TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      c_LAST_CHAR = 3'(c_CHARS_PER_WORD - 1);
    localparam logic [2:0]      c_NUM_HEX   = 3'(c_HEX_CHARS);

    // ---------------------------------------------------------------- FIFO
    logic [DATA_WIDTH-1:0] r_mem_q [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr_q,   w_wr_ptr_d;
    logic [c_AW-1:0]       r_rd_ptr_q,   w_rd_ptr_d;
    logic [c_CW-1:0]       r_count_q,    w_count_d;
    logic                  r_overflow_q, w_overflow_d;
    logic                  w_full, w_empty, w_push, w_pop;
    logic [DATA_WIDTH-1:0] w_head;

    // ----------------------------------------------------------- sequencer
    seq_state_t            r_state_q,    w_state_d;
    logic [c_TW-1:0]       r_timer_q,    w_timer_d;
    logic [2:0]            r_bit_q,      w_bit_d;
    logic [2:0]            r_char_idx_q, w_char_idx_d;
    logic [DATA_WIDTH-1:0] r_word_q,     w_word_d;
    logic                  r_start_q,    w_start_d;
    logic [7:0]            r_char_q,     w_char_d;
    logic                  w_bit_end;
    logic [2:0]            w_next_idx;
    logic [7:0]            w_seq_char;
    logic                  w_byte_done;

    assign w_full  = (r_count_q == c_CW'(FIFO_DEPTH));
    assign w_empty = (r_count_q == '0);
    assign w_pop   = (r_state_q == ST_IDLE) && !w_empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push  = data_valid && !reset && (!w_full || w_pop);
    assign w_head  = r_mem_q[r_rd_ptr_q];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= data_in;
        end
    end

    always_comb begin
        w_wr_ptr_d   = w_push ? r_wr_ptr_q + 1'b1 : r_wr_ptr_q;
        w_rd_ptr_d   = w_pop  ? r_rd_ptr_q + 1'b1 : r_rd_ptr_q;
        w_count_d    = r_count_q;
        w_overflow_d = r_overflow_q | (data_valid && w_full && !w_pop);
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    assign w_bit_end  = (r_timer_q == c_TMAX);
    assign w_next_idx = r_char_idx_q + 3'd1;

    always_comb begin
        w_seq_char = c_ASCII_LF;
        if (w_next_idx < c_NUM_HEX) begin
            w_seq_char = hex_to_ascii(r_word_q[DATA_WIDTH-1 -: 4]);
        end else if (w_next_idx == c_NUM_HEX) begin
            w_seq_char = c_ASCII_CR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            r_overflow_q <= 1'b0;
            r_state_q    <= ST_IDLE;
            r_timer_q    <= '0;
            r_bit_q      <= '0;
            r_char_idx_q <= '0;
            r_word_q     <= '0;
            r_start_q    <= 1'b0;
            r_char_q     <= '0;
        end else begin
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_count_q    <= w_count_d;
            r_overflow_q <= w_overflow_d;
            r_state_q    <= w_state_d;
            r_timer_q    <= w_timer_d;
            r_bit_q      <= w_bit_d;
            r_char_idx_q <= w_char_idx_d;
            r_word_q     <= w_word_d;
            r_start_q    <= w_start_d;
            r_char_q     <= w_char_d;
        end
    end

    // The serializer runs one cycle behind this FSM because each character is
    // handed over through the registered start pulse.
    always_comb begin
        w_state_d    = r_state_q;
        w_timer_d    = w_bit_end ? '0 : r_timer_q + 1'b1;
        w_bit_d      = r_bit_q;
        w_char_idx_d = r_char_idx_q;
        w_word_d     = r_word_q;
        w_start_d    = 1'b0;
        w_char_d     = r_char_q;
        case (r_state_q)
            ST_IDLE: begin
                w_timer_d = '0;
                if (w_pop) begin
                    w_state_d    = ST_START;
                    w_char_idx_d = '0;
                    w_word_d     = {w_head[DATA_WIDTH-5:0], 4'h0};
                    w_char_d     = hex_to_ascii(w_head[DATA_WIDTH-1 -: 4]);
                    w_start_d    = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_d = ST_DATA;
                    w_bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_q == 3'd7) begin
                        w_state_d = ST_STOP;
                    end else begin
                        w_bit_d = r_bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (r_char_idx_q < c_LAST_CHAR) begin
                    if (w_bit_end) begin
                        w_state_d    = ST_START;
                        w_char_idx_d = w_next_idx;
                        w_char_d     = w_seq_char;
                        w_start_d    = 1'b1;
                        if (w_next_idx < c_NUM_HEX) begin
                            w_word_d = {r_word_q[DATA_WIDTH-5:0], 4'h0};
                        end
                    end
                end else if (w_byte_done) begin
                    // Hold off IDLE until the final stop bit is really on the line.
                    w_state_d    = ST_IDLE;
                    w_timer_d    = '0;
                    w_char_idx_d = '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk    (clk),
        .reset  (reset),
        .byte_in(r_char_q),
        .start  (r_start_q),
        .tx     (tx),
        .done   (w_byte_done)
    );

    assign busy       = (r_state_q != ST_IDLE) || (r_count_q != '0);
    assign fifo_count = r_count_q;
    assign overflow   = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_uart_tx
// Purpose  : Self-checking bench for result_uart_tx with a UART monitor and a
//            character scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_result_uart_tx;

    localparam int CPB   = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 60 * CPB;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data_in    = '0;
    logic          tx, busy, overflow;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [15:0] word;
        logic [47:0] frame;
    } vec_t;
    vec_t vecs [6];

    result_uart_tx #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [47:0] model_frame(input logic [15:0] w);
        logic [47:0] f;
        logic [3:0]  n;
        for (int i = 0; i < 4; i++) begin
            n = w[15 - 4*i -: 4];
            f[47 - 8*i -: 8] = (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
        end
        f[15:8] = 8'h0D;
        f[7:0]  = 8'h0A;
        return f;
    endfunction

    // ------------------------------------------------------------ UART monitor
    int         mon_k = -1;
    int         mon_started = 0;
    int         mon_last_start = 0;
    int         mon_last_end = 0;
    logic [7:0] mon_byte = '0;
    logic       mon_bad = 1'b0;

    always @(negedge clk) begin
        int slot, ph;
        if (reset) begin
            mon_k = -1;
        end else if (mon_k < 0) begin
            if (tx === 1'b0) begin
                mon_k          = 1;
                mon_bad        = 1'b0;
                mon_started++;
                mon_last_start = cyc;
            end
        end else begin
            slot = mon_k / CPB;
            ph   = mon_k % CPB;
            if (slot == 0) begin
                if (tx !== 1'b0) mon_bad = 1'b1;
            end else if (slot <= 8) begin
                if (ph == 0) mon_byte[slot-1] = tx;
                else if (tx !== mon_byte[slot-1]) mon_bad = 1'b1;
            end else begin
                if (tx !== 1'b1) mon_bad = 1'b1;
            end
            mon_k++;
            if (mon_k == 10 * CPB) begin
                check("uart_framing", {31'd0, mon_bad}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("uart_unexpected_char", {24'd0, mon_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("uart_char", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                end
                mon_last_end = cyc;
                mon_k        = -1;
            end
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic push(input logic [15:0] w, input bit accept, input logic [47:0] frame);
        data_in    = w;
        data_valid = 1'b1;
        if (accept) begin
            for (int i = 0; i < 6; i++) exp_q.push_back(frame[47 - 8*i -: 8]);
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_start(input int prev, output int s);
        int n = 0;
        while (mon_started == prev && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("start_timeout", {31'd0, (n >= 50)}, 32'd0);
        s = mon_last_start;
    endtask

    task automatic wait_busy_low(input int budget, output int b);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", {31'd0, (n >= budget)}, 32'd0);
        b = cyc;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        int e, s, b, p, prev;
        vecs[0] = '{16'h1A2F, {8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A}};
        vecs[1] = '{16'h0000, {8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}};
        vecs[2] = '{16'hFFFF, {8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A}};
        vecs[3] = '{16'h00FF, {8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A}};
        vecs[4] = '{16'h9B5C, {8'h39, 8'h42, 8'h35, 8'h43, 8'h0D, 8'h0A}};
        vecs[5] = '{16'hE370, {8'h45, 8'h33, 8'h37, 8'h30, 8'h0D, 8'h0A}};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_count", {28'd0, fifo_count}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);

        // Single words from the table: latency, frame length, busy drop.
        for (int v = 0; v < 6; v++) begin
            prev = mon_started;
            push(vecs[v].word, 1'b1, vecs[v].frame);
            e = cyc;
            wait_start(prev, s);
            check("start_latency", s - e, 32'd2);
            wait_busy_low(FRAME + 50, b);
            check("busy_drop_cycle", b - s, FRAME);
            check("frame_len", mon_last_end - s + 1, FRAME);
            check("sb_empty", exp_q.size(), 32'd0);
        end

        // Extremes queued behind a running word: count 1,2,1,0 and idle gap.
        push(16'h1234, 1'b1, model_frame(16'h1234));
        repeat (3) @(negedge clk);
        push(16'h0000, 1'b1, model_frame(16'h0000));
        check("ext_count_1", {28'd0, fifo_count}, 32'd1);
        push(16'hFFFF, 1'b1, model_frame(16'hFFFF));
        check("ext_count_2", {28'd0, fifo_count}, 32'd2);
        for (int n = 0; n < FRAME + 20 && fifo_count == 2; n++) @(negedge clk);
        check("ext_count_3", {28'd0, fifo_count}, 32'd1);
        for (int n = 0; n < FRAME + 20 && fifo_count == 1; n++) @(negedge clk);
        check("ext_count_4", {28'd0, fifo_count}, 32'd0);
        p = cyc;
        check("idle_gap_ok", {31'd0, (p - mon_last_end >= 1)}, 32'd1);
        wait_busy_low(2 * FRAME + 50, b);
        check("ext_sb_empty", exp_q.size(), 32'd0);

        // Overflow: 10 back-to-back words from empty, the tenth is dropped.
        for (int i = 1; i <= 10; i++) begin
            push(16'(i), (i <= 9), model_frame(16'(i)));
        end
        check("ovf_count", {28'd0, fifo_count}, 32'd8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        wait_busy_low(9 * (FRAME + 10) + 50, b);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_sb_empty", exp_q.size(), 32'd0);

        do_reset();
        check("rst_overflow_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO with a push landing on the exact IDLE pop cycle.
        prev = mon_started;
        push(16'hA5A5, 1'b1, model_frame(16'hA5A5));
        for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i), 1'b1, model_frame(16'h0100 + 16'(i)));
        check("full_count", {28'd0, fifo_count}, 32'd8);
        check("full_started", mon_started - prev, 32'd1);
        s = mon_last_start;
        while (cyc < s + FRAME) @(negedge clk);
        push(16'h0F0F, 1'b1, model_frame(16'h0F0F));
        check("pushpop_count", {28'd0, fifo_count}, 32'd8);
        check("pushpop_overflow", {31'd0, overflow}, 32'd0);
        wait_busy_low(10 * (FRAME + 10) + 50, b);
        check("pushpop_sb_empty", exp_q.size(), 32'd0);
        check("pushpop_ovf_final", {31'd0, overflow}, 32'd0);

        // Reset during data bit 3 of character 2, with data_valid held high.
        prev = mon_started;
        push(16'h1234, 1'b1, model_frame(16'h1234));
        push(16'h5678, 1'b1, model_frame(16'h5678));
        wait_start(prev, s);
        while (cyc < s + 2*10*CPB + 4*CPB + 1) @(negedge clk);
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 16'hBEEF;
        @(negedge clk);
        exp_q.delete();
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_count", {28'd0, fifo_count}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        check("rst_push_ignored", {28'd0, fifo_count}, 32'd0);
        check("rst_busy_after", {31'd0, busy}, 32'd0);
        check("rst_tx_after", {31'd0, tx}, 32'd1);
        prev = mon_started;
        push(16'h00FF, 1'b1, {8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A});
        e = cyc;
        wait_start(prev, s);
        check("post_rst_latency", s - e, 32'd2);
        wait_busy_low(FRAME + 50, b);
        check("post_rst_frame", mon_last_end - s + 1, FRAME);
        check("post_rst_sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
